div_seq_ctrl: RTL and testbench
===============================

Name: div_seq_ctrl

Overview:
- Multi-cycle sequencer for the RV32M divide/remainder datapath (ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU) in the EX stage.
- Accepts one operation from EX and runs a 32-iteration restoring division.
- Drives the division stall used to form hazard_t.division, and returns a sign-corrected result with a one-cycle done pulse.
- Division-by-zero and signed overflow are resolved without iterating.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.
- CNT_W, $clog2(XLEN)+1, iteration counter width.

Ports:
- clk  input  1  core clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- valid_i  input  1  EX holds a valid instruction
- op_i  input  5  alu_op_e of the EX instruction; only DIV/DIVU/REM/REMU start the block
- a_i  input  XLEN  dividend (rs1, forwarded); held stable by EX while stall_o=1
- b_i  input  XLEN  divisor (rs2, forwarded); held stable by EX while stall_o=1
- flush_i  input  1  EX instruction killed (branch mispredict/redirect)
- stall_o  output  1  hold IF/ID/EX; feeds hazard_t.division
- busy_o  output  1  state != IDLE
- done_o  output  1  one-cycle pulse, result_o valid
- result_o  output  XLEN  quotient or remainder

Behaviour:
- Clock/reset: one clock (clk). Reset (rst) is synchronous and active-high.
- Reset values: state=IDLE, counter=0, done_o=0, result_o=0, busy_o=0, stall_o=0. A reset mid-operation abandons the operation and does not assert done.
- is_div = valid_i & op_i in {DIV, DIVU, REM, REMU}. Other ops are ignored.
- stall_o = is_div & ~done_o & ~flush_i (combinational). EX advances on the edge where done_o=1.
- States: IDLE, CALC, FIX, DONE.
- IDLE, start condition (is_div & ~flush_i at edge T):
  - Signed ops (DIV/REM): latch |a|, |b|, neg_q = a[31]^b[31] (when b!=0), neg_r = a[31].
  - Unsigned ops: latch a and b unchanged.
  - Clear remainder, counter=0.
  - Special case b==0: result = all-ones for DIV/DIVU, a_i for REM/REMU.
  - Special case signed overflow (DIV/REM, a=0x80000000, b=0xFFFFFFFF): result = 0x80000000 for DIV, 0 for REM.
  - Special cases go to DONE. Otherwise go to CALC.
- CALC: one restoring step per cycle, MSB-first:
  - rem' = {rem[XLEN-2:0], dvd[XLEN-1]}, dvd shifts left.
  - If rem' >= divisor: rem' -= divisor and quotient bit = 1.
  - Counter increments; after XLEN steps (counter==XLEN-1 on the step edge) go to FIX.
- FIX: negate the quotient if neg_q; negate the remainder if neg_r (signed ops only). Select quotient or remainder per the latched op into result_o. Go to DONE.
- DONE: done_o=1 for exactly one cycle, result_o held. Next state is IDLE. A new start is not accepted in DONE.
- Latency:
  - Normal op: start at edge T, CALC T+1..T+32, FIX at T+33, done_o high in cycle after edge T+34.
  - Special case: done_o high in the cycle after edge T+1.
  - result_o holds its value until the next done.
- Back-to-back: the next DIV in EX starts in the IDLE cycle following DONE. Throughput is 1 op per 35 cycles.
- flush_i in any state: next state IDLE, done_o not asserted, counter cleared. flush_i has priority over start and completion. flush_i in the DONE cycle suppresses done_o.
- Operand changes on a_i/b_i after start have no effect; values are latched.

Decomposition:
- riscv_pkg additions:
  - div_state_e (IDLE, CALC, FIX, DONE; 2-bit).
  - DIV_ITERS = XLEN.
  - DIV_ZERO_Q = '1.
  - DIV_OVF_DVD = 32'h80000000.
- Sub-module div_restore_step (combinational): inputs rem, dvd_msb, divisor; outputs next rem and q_bit.
- The sequencer, counter, sign logic and special-case detection stay in div_seq_ctrl.

Test Plan:
- DIV a=100, b=7 → stall_o high 34 cycles, done_o pulse, result_o=14. Same operands with REM → 2.
- DIV a=-20 (0xFFFFFFEC), b=6 → 0xFFFFFFFD (-3). REM → 0xFFFFFFFE (-2). DIVU same operands → 0x2AAAAAA7.
- DIVU a=5, b=0 → done after 2 cycles, result 0xFFFFFFFF. REMU → 5. DIV a=0x80000000, b=0xFFFFFFFF → 0x80000000. REM → 0.
- Start DIV 100/7, assert flush_i at CALC cycle 10 → busy_o=0 next cycle, no done_o. Then DIVU 9/3 completes with 3.
- Two consecutive DIVs (1000/10, then 81/9) → results 100 and 9, second done exactly 35 cycles after the first. Non-div op with valid_i → stall_o=0, state IDLE.
- rst asserted during CALC → next cycle all outputs 0, state IDLE. A subsequent DIV 50/5 returns 10.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32 core types: ALU op encoding and the divide sequencer state/constants.
// Pure declarations; no logic, no latency.
package riscv_pkg;

    localparam int RV_XLEN = 32;

    typedef enum logic [4:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA,
        ALU_SLT, ALU_SLTU, ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
        ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
    } alu_op_e;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_FIX  = 2'd2,
        DIV_DONE = 2'd3
    } div_state_e;

    localparam int                 DIV_ITERS   = RV_XLEN;
    localparam logic [RV_XLEN-1:0] DIV_ZERO_Q  = '1;
    localparam logic [RV_XLEN-1:0] DIV_OVF_DVD = 32'h8000_0000;

    function automatic logic is_div_op(input logic [4:0] op);
        return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
    endfunction

endpackage

// File: rtl/div_restore_step.sv
// One MSB-first restoring-division step; purely combinational.
// The trial value keeps one extra bit so divisors with the top bit set stay exact.
module div_restore_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem,
    input  logic            dvd_msb,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_next,
    output logic            q_bit
);

    logic [XLEN:0] trial;
    logic [XLEN:0] diff;

    assign trial    = {rem, dvd_msb};
    assign diff     = trial - {1'b0, divisor};
    assign q_bit    = (trial >= {1'b0, divisor});
    assign rem_next = q_bit ? diff[XLEN-1:0] : trial[XLEN-1:0];

endmodule

// File: rtl/div_seq_ctrl.sv
// RV32M DIV/DIVU/REM/REMU sequencer: 35 cycles start-to-done (2 for /0 and overflow).
// Stalls EX until the registered done pulse; flush abandons the op silently.
module div_seq_ctrl
    import riscv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    input  logic [4:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam logic [1:0] IDLE = DIV_IDLE;
    localparam logic [1:0] CALC = DIV_CALC;
    localparam logic [1:0] FIX  = DIV_FIX;
    localparam logic [1:0] DONE = DIV_DONE;

    localparam logic [XLEN-1:0] ZERO_Q  = XLEN'(DIV_ZERO_Q);
    localparam logic [XLEN-1:0] OVF_DVD = XLEN'(DIV_OVF_DVD);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0]  dvd;
    logic [XLEN-1:0]  dvs;
    logic [XLEN-1:0]  rem;
    logic [XLEN-1:0]  res;
    logic             neg_q;
    logic             neg_r;
    logic             op_rem;

    logic             is_div;
    logic             op_signed;
    logic             op_is_rem;
    logic             b_zero;
    logic             ovf;
    logic [XLEN-1:0]  a_abs;
    logic [XLEN-1:0]  b_abs;
    logic [XLEN-1:0]  rem_step;
    logic             q_bit;

    assign is_div    = valid_i & is_div_op(op_i);
    assign op_signed = (op_i == ALU_DIV) | (op_i == ALU_REM);
    assign op_is_rem = (op_i == ALU_REM) | (op_i == ALU_REMU);
    assign b_zero    = (b_i == '0);
    assign ovf       = op_signed & (a_i == OVF_DVD) & (b_i == '1);
    assign a_abs     = a_i[XLEN-1] ? -a_i : a_i;
    assign b_abs     = b_i[XLEN-1] ? -b_i : b_i;

    assign stall_o = is_div & ~done_o & ~flush_i;
    assign busy_o  = (state != IDLE);

    div_restore_step #(.XLEN(XLEN)) u_step (
        .rem      (rem),
        .dvd_msb  (dvd[XLEN-1]),
        .divisor  (dvs),
        .rem_next (rem_step),
        .q_bit    (q_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            done_o   <= 1'b0;
            result_o <= '0;
            dvd      <= '0;
            dvs      <= '0;
            rem      <= '0;
            res      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            op_rem   <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (flush_i) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (is_div) begin
                            op_rem <= op_is_rem;
                            rem    <= '0;
                            cnt    <= '0;
                            if (op_signed) begin
                                dvd   <= a_abs;
                                dvs   <= b_abs;
                                neg_q <= a_i[XLEN-1] ^ b_i[XLEN-1];
                                neg_r <= a_i[XLEN-1];
                            end else begin
                                dvd   <= a_i;
                                dvs   <= b_i;
                                neg_q <= 1'b0;
                                neg_r <= 1'b0;
                            end
                            // Special cases bypass iteration and report straight from DONE
                            if (b_zero) begin
                                res   <= op_is_rem ? a_i : ZERO_Q;
                                state <= DONE;
                            end else if (ovf) begin
                                res   <= op_is_rem ? '0 : OVF_DVD;
                                state <= DONE;
                            end else begin
                                state <= CALC;
                            end
                        end
                    end
                    CALC: begin
                        // dvd doubles as the quotient: bits shift out the top, q bits in the bottom
                        rem <= rem_step;
                        dvd <= {dvd[XLEN-2:0], q_bit};
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(XLEN - 1)) begin
                            state <= FIX;
                        end
                    end
                    FIX: begin
                        res   <= op_rem ? (neg_r ? -rem : rem) : (neg_q ? -dvd : dvd);
                        state <= DONE;
                    end
                    DONE: begin
                        done_o   <= 1'b1;
                        result_o <= res;
                        state    <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed bench for div_seq_ctrl: vector table plus flush, reset and back-to-back sequences.
module tb_div_seq_ctrl;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic [4:0]  op_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        flush_i;
    logic        stall_o;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    div_seq_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .valid_i  (valid_i),
        .op_i     (op_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .flush_i  (flush_i),
        .stall_o  (stall_o),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called just after a falling edge; returns once done_o is seen (or the budget runs out).
    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int cyc, output int stl);
        valid_i = 1'b1;
        op_i    = op;
        a_i     = a;
        b_i     = b;
        res     = 'x;
        cyc     = 0;
        stl     = 0;
        while (cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                a_i = ~a;
                b_i = '0;
            end
            if (done_o === 1'b1) begin
                res = result_o;
                break;
            end
            if (stall_o === 1'b1) stl++;
        end
        valid_i = 1'b0;
        op_i    = ALU_ADD;
        a_i     = '0;
        b_i     = '0;
    endtask

    initial begin
        logic [31:0] res;
        int          cyc;
        int          stl;
        int          t0;
        int          t1;
        int          dones;
        logic [31:0] r0;
        logic [31:0] r1;

        vecs[0]  = '{ALU_DIV,  32'd100,        32'd7,          32'd14,         35};
        vecs[1]  = '{ALU_REM,  32'd100,        32'd7,          32'd2,          35};
        vecs[2]  = '{ALU_DIV,  32'hFFFF_FFEC,  32'd6,          32'hFFFF_FFFD,  35};
        vecs[3]  = '{ALU_REM,  32'hFFFF_FFEC,  32'd6,          32'hFFFF_FFFE,  35};
        vecs[4]  = '{ALU_DIVU, 32'hFFFF_FFEC,  32'd6,          32'h2AAA_AAA7,  35};
        vecs[5]  = '{ALU_REMU, 32'hFFFF_FFEC,  32'd6,          32'd2,          35};
        vecs[6]  = '{ALU_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  35};
        vecs[7]  = '{ALU_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          35};
        vecs[8]  = '{ALU_DIVU, 32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'd1,          35};
        vecs[9]  = '{ALU_REMU, 32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'd1,          35};
        vecs[10] = '{ALU_DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF,  2};
        vecs[11] = '{ALU_REMU, 32'd5,          32'd0,          32'd5,          2};
        vecs[12] = '{ALU_DIV,  32'd5,          32'd0,          32'hFFFF_FFFF,  2};
        vecs[13] = '{ALU_REM,  32'hFFFF_FFEC,  32'd0,          32'hFFFF_FFEC,  2};
        vecs[14] = '{ALU_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  2};
        vecs[15] = '{ALU_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          2};
        vecs[16] = '{ALU_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          35};
        vecs[17] = '{ALU_DIV,  32'd0,          32'd3,          32'd0,          35};

        rst     = 1'b1;
        valid_i = 1'b0;
        op_i    = ALU_ADD;
        a_i     = '0;
        b_i     = '0;
        flush_i = 1'b0;
        repeat (3) @(negedge clk);
        check("reset stall", {31'd0, stall_o}, 32'd0);
        check("reset busy",  {31'd0, busy_o},  32'd0);
        check("reset done",  {31'd0, done_o},  32'd0);
        check("reset result", result_o, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, cyc, stl);
            check($sformatf("vec%0d result", i), res, vecs[i].exp);
            check($sformatf("vec%0d latency", i), 32'(cyc), 32'(vecs[i].lat));
            check($sformatf("vec%0d stall cycles", i), 32'(stl), 32'(vecs[i].lat - 1));
            @(negedge clk);
            check($sformatf("vec%0d busy after", i), {31'd0, busy_o}, 32'd0);
        end

        // Non-divide op in EX never stalls or starts the sequencer
        valid_i = 1'b1;
        op_i    = ALU_MUL;
        a_i     = 32'd100;
        b_i     = 32'd7;
        #1;
        check("nondiv stall", {31'd0, stall_o}, 32'd0);
        @(negedge clk);
        check("nondiv busy", {31'd0, busy_o}, 32'd0);
        valid_i = 1'b0;

        // Flush in the 10th CALC cycle
        valid_i = 1'b1;
        op_i    = ALU_DIV;
        a_i     = 32'd100;
        b_i     = 32'd7;
        repeat (10) @(negedge clk);
        check("flush calc busy", {31'd0, busy_o}, 32'd1);
        flush_i = 1'b1;
        #1;
        check("flush stall", {31'd0, stall_o}, 32'd0);
        @(negedge clk);
        flush_i = 1'b0;
        valid_i = 1'b0;
        check("flush busy next", {31'd0, busy_o}, 32'd0);
        dones = 0;
        repeat (40) begin
            if (done_o === 1'b1) dones++;
            @(negedge clk);
        end
        check("flush no done", 32'(dones), 32'd0);
        run_op(ALU_DIVU, 32'd9, 32'd3, res, cyc, stl);
        check("post flush divu", res, 32'd3);
        @(negedge clk);

        // Flush during the DONE cycle of a special-case op
        valid_i = 1'b1;
        op_i    = ALU_DIVU;
        a_i     = 32'd5;
        b_i     = 32'd0;
        @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        valid_i = 1'b0;
        check("flush done pulse", {31'd0, done_o}, 32'd0);
        check("flush done result", result_o, 32'd3);
        @(negedge clk);
        check("flush done busy", {31'd0, busy_o}, 32'd0);

        // Back-to-back: second op presented during the first done cycle
        valid_i = 1'b1;
        op_i    = ALU_DIV;
        a_i     = 32'd1000;
        b_i     = 32'd10;
        t0 = -1;
        t1 = -1;
        r0 = 'x;
        r1 = 'x;
        for (int c = 1; c <= 120; c++) begin
            @(negedge clk);
            if (done_o === 1'b1) begin
                if (t0 < 0) begin
                    t0 = c;
                    r0 = result_o;
                    a_i = 32'd81;
                    b_i = 32'd9;
                end else begin
                    t1 = c;
                    r1 = result_o;
                    valid_i = 1'b0;
                    break;
                end
            end
        end
        valid_i = 1'b0;
        check("b2b first", r0, 32'd100);
        check("b2b second", r1, 32'd9);
        check("b2b spacing", 32'(t1 - t0), 32'd35);
        @(negedge clk);

        // Reset in the middle of CALC
        valid_i = 1'b1;
        op_i    = ALU_DIV;
        a_i     = 32'd100;
        b_i     = 32'd7;
        repeat (5) @(negedge clk);
        rst     = 1'b1;
        valid_i = 1'b0;
        @(negedge clk);
        check("midrst stall", {31'd0, stall_o}, 32'd0);
        check("midrst busy",  {31'd0, busy_o},  32'd0);
        check("midrst done",  {31'd0, done_o},  32'd0);
        check("midrst result", result_o, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        run_op(ALU_DIV, 32'd50, 32'd5, res, cyc, stl);
        check("post reset div", res, 32'd10);
        check("post reset latency", 32'(cyc), 32'd35);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
